// File: rtl/mem_access_ctrl.sv
// MEM-stage load/store sequencer for a single-port, variable-latency data bus.
// Handles lane enables, store replication, load extension, misalignment and timeout.
module mem_access_ctrl #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [2:0]  req_type,
    input  logic        req_sign,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        stall,
    output logic        done,
    output logic [31:0] rdata,
    output logic        adel,
    output logic        ades,
    output logic        bus_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        BUS,
        RESP
    } state_t;

    localparam bit HAS_TO = (TIMEOUT > 0);
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             lat_word;
    logic             lat_half;
    logic             lat_sign;
    logic             lat_we;
    logic [1:0]       lat_off;

    logic             is_word;
    logic             is_half;
    logic             misal;
    logic             idle_req;
    logic             accept;
    logic             to_hit;
    logic [3:0]       be_d;
    logic [31:0]      wd_d;
    logic [7:0]       ld_b;
    logic [15:0]      ld_h;
    logic [31:0]      ld_ext;

    always_comb begin
        is_word  = (req_type == 3'd0);
        is_half  = (req_type == 3'd1);
        misal    = (is_word & |req_addr[1:0]) | (is_half & req_addr[0]);
        // reset gate keeps the comb outputs quiet while reset is held
        idle_req = !reset && (state == IDLE) && req_valid;
        accept   = idle_req && !misal;
        adel     = idle_req && misal && !req_we;
        ades     = idle_req && misal && req_we;
        stall    = accept || (state == BUS);
        to_hit   = HAS_TO && (cnt == CNT_LAST);

        be_d = 4'b0000;
        wd_d = 32'h0;
        unique case (1'b1)
            is_word: begin
                be_d = 4'b1111;
                wd_d = req_wdata;
            end
            is_half: begin
                be_d = req_addr[1] ? 4'b1100 : 4'b0011;
                wd_d = {2{req_wdata[15:0]}};
            end
            default: begin
                be_d = 4'b0001 << req_addr[1:0];
                wd_d = {4{req_wdata[7:0]}};
            end
        endcase

        ld_h = lat_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        ld_b = 8'h0;
        unique case (lat_off)
            2'd0:    ld_b = mem_rdata[7:0];
            2'd1:    ld_b = mem_rdata[15:8];
            2'd2:    ld_b = mem_rdata[23:16];
            default: ld_b = mem_rdata[31:24];
        endcase

        ld_ext = 32'h0;
        unique case (1'b1)
            lat_word: ld_ext = mem_rdata;
            lat_half: ld_ext = {{16{lat_sign & ld_h[15]}}, ld_h};
            default:  ld_ext = {{24{lat_sign & ld_b[7]}}, ld_b};
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            lat_word  <= 1'b0;
            lat_half  <= 1'b0;
            lat_sign  <= 1'b0;
            lat_we    <= 1'b0;
            lat_off   <= 2'd0;
            done      <= 1'b0;
            bus_err   <= 1'b0;
            rdata     <= 32'h0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'h0;
            mem_be    <= 4'h0;
            mem_wdata <= 32'h0;
        end else begin
            unique case (state)
                IDLE: begin
                    done    <= 1'b0;
                    bus_err <= 1'b0;
                    rdata   <= 32'h0;
                    if (accept) begin
                        lat_word  <= is_word;
                        lat_half  <= is_half;
                        lat_sign  <= req_sign;
                        lat_we    <= req_we;
                        lat_off   <= req_addr[1:0];
                        mem_req   <= 1'b1;
                        mem_we    <= req_we;
                        mem_addr  <= {req_addr[31:2], 2'b00};
                        mem_be    <= be_d;
                        mem_wdata <= wd_d;
                        cnt       <= '0;
                        state     <= BUS;
                    end
                end
                BUS: begin
                    if (mem_ack) begin
                        rdata   <= lat_we ? 32'h0 : ld_ext;
                        done    <= 1'b1;
                        mem_req <= 1'b0;
                        state   <= RESP;
                    end else if (to_hit) begin
                        rdata   <= 32'h0;
                        bus_err <= 1'b1;
                        done    <= 1'b1;
                        mem_req <= 1'b0;
                        state   <= RESP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RESP: begin
                    done    <= 1'b0;
                    bus_err <= 1'b0;
                    rdata   <= 32'h0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
